// File: rtl/display_pattern_gen.sv
// Frame-synchronised VGA test-pattern generator with manual/auto mode selection,
// tear-free mode switching and a 2-cycle coordinate-to-pixel pipeline.
module display_pattern_gen #(
  parameter int unsigned H_DISP          = 1280,
  parameter int unsigned V_DISP          = 1024,
  parameter int unsigned PIXEL_FREQUENCY = 108_000_000,
  parameter int unsigned DWELL_SEC       = 3,
  parameter int unsigned GRID_SHIFT_S    = 4,
  parameter int unsigned GRID_SHIFT_L    = 6,
  parameter int unsigned BAR_COUNT       = 8,
  parameter int unsigned SCROLL_STEP     = 1
) (
  input  logic        clk_vga_display,
  input  logic        rst_n_display,
  input  logic [11:0] xpos_vga_display,
  input  logic [11:0] ypos_vga_display,
  input  logic        pix_req,
  input  logic        frame_start,
  input  logic        auto_mode,
  input  logic [3:0]  mode_sel,
  input  logic        freeze,
  output logic [15:0] data_vga_display,
  output logic        data_valid,
  output logic [3:0]  mode_cur
);

  typedef enum logic [2:0] {
    RED, GREEN, BLUE, WHITE, BLACK, YELLOW, MAGENTA, CYAN
  } colour_t;

  localparam int unsigned BAR_H = V_DISP / BAR_COUNT;
  localparam int unsigned BAR_W = H_DISP / BAR_COUNT;

  function automatic logic [15:0] rgb(input colour_t c);
    case (c)
      RED:     return 16'hF800;
      GREEN:   return 16'h07E0;
      BLUE:    return 16'h001F;
      WHITE:   return 16'hFFFF;
      YELLOW:  return 16'hFFE0;
      MAGENTA: return 16'hF81F;
      CYAN:    return 16'h07FF;
      default: return 16'h0000;
    endcase
  endfunction

  logic [27:0] sec_cnt;
  logic [4:0]  dwell_cnt;
  logic        pending;
  logic [3:0]  mode_q;
  logic [3:0]  mode_next;
  logic [11:0] scroll_off;
  logic        sec_tick;
  logic        dwell_wrap;

  assign sec_tick   = !freeze && (sec_cnt == 28'(PIXEL_FREQUENCY - 1));
  assign dwell_wrap = sec_tick && (dwell_cnt == 5'(DWELL_SEC - 1));
  assign mode_cur   = mode_q;

  always_comb begin
    mode_next = mode_q;
    if (frame_start) begin
      if (!auto_mode)
        mode_next = mode_sel;
      else if (pending)
        mode_next = (mode_q == 4'd9) ? '0 : mode_q + 4'd1;
    end
  end

  always_ff @(posedge clk_vga_display or negedge rst_n_display) begin
    if (!rst_n_display) begin
      sec_cnt    <= '0;
      dwell_cnt  <= '0;
      pending    <= 1'b0;
      mode_q     <= '0;
      scroll_off <= '0;
    end else begin
      if (!freeze)
        sec_cnt <= sec_tick ? '0 : sec_cnt + 28'd1;
      // A pending flag raised by a tick on the frame_start cycle survives to the next frame
      if (frame_start && !auto_mode) begin
        dwell_cnt <= '0;
        pending   <= 1'b0;
      end else begin
        if (sec_tick)
          dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + 5'd1;
        if (dwell_wrap)
          pending <= 1'b1;
        else if (frame_start && pending)
          pending <= 1'b0;
      end
      mode_q <= mode_next;
      if (frame_start) begin
        if (mode_next == 4'd8 && mode_q != 4'd8)
          scroll_off <= '0;
        else if (mode_q == 4'd8 && !freeze)
          scroll_off <= scroll_off + 12'(SCROLL_STEP);
      end
    end
  end

  // Stage 1: registered coordinates plus the mode/scroll they were launched with
  logic [11:0] x1, y1, scroll1;
  logic [3:0]  mode1;
  logic        req1, act1;

  logic [11:0] xs;
  logic [15:0] flower;
  logic [2:0]  hbar, vbar;
  logic        chk_s, chk_l, chk_scroll, border;
  logic [15:0] pix;

  assign xs         = x1 + scroll1;
  assign flower     = {4'b0, x1} * {4'b0, y1};
  assign chk_s      = x1[GRID_SHIFT_S] ^ y1[GRID_SHIFT_S];
  assign chk_l      = x1[GRID_SHIFT_L] ^ y1[GRID_SHIFT_L];
  assign chk_scroll = xs[GRID_SHIFT_L] ^ y1[GRID_SHIFT_L];
  assign border     = (x1 == '0) || (x1 == 12'(H_DISP - 1)) || (x1 == 12'(H_DISP / 2)) ||
                      (y1 == '0) || (y1 == 12'(V_DISP - 1)) || (y1 == 12'(V_DISP / 2));

  // Constant-threshold compare chain; remainder pixels saturate at the last bar
  always_comb begin
    hbar = '0;
    vbar = '0;
    for (int unsigned k = 1; k < BAR_COUNT; k++) begin
      if (32'(y1) >= k * BAR_H) hbar = 3'(k);
      if (32'(x1) >= k * BAR_W) vbar = 3'(k);
    end
  end

  always_comb begin
    pix = rgb(BLACK);
    case (mode1)
      4'd0:    pix = chk_s ? rgb(WHITE) : rgb(BLACK);
      4'd1:    pix = chk_l ? rgb(WHITE) : rgb(BLACK);
      4'd2:    pix = rgb(colour_t'(hbar));
      4'd3:    pix = rgb(colour_t'(vbar));
      4'd4:    pix = rgb(RED);
      4'd5:    pix = rgb(GREEN);
      4'd6:    pix = rgb(BLUE);
      4'd7:    pix = flower;
      4'd8:    pix = chk_scroll ? rgb(WHITE) : rgb(BLACK);
      4'd9:    pix = border ? rgb(WHITE) : rgb(BLACK);
      default: pix = rgb(BLACK);
    endcase
  end

  always_ff @(posedge clk_vga_display or negedge rst_n_display) begin
    if (!rst_n_display) begin
      x1               <= '0;
      y1               <= '0;
      scroll1          <= '0;
      mode1            <= '0;
      req1             <= 1'b0;
      act1             <= 1'b0;
      data_vga_display <= '0;
      data_valid       <= 1'b0;
    end else begin
      x1               <= xpos_vga_display;
      y1               <= ypos_vga_display;
      scroll1          <= scroll_off;
      mode1            <= mode_q;
      req1             <= pix_req;
      act1             <= pix_req && (32'(xpos_vga_display) < H_DISP) &&
                          (32'(ypos_vga_display) < V_DISP);
      data_vga_display <= act1 ? pix : '0;
      data_valid       <= req1;
    end
  end

endmodule

// File: tb/tb_display_pattern_gen.sv
// Scoreboarded random/directed bench for display_pattern_gen against a
// behavioural model of mode sequencing, scrolling and pattern rules.
module tb_display_pattern_gen;
  localparam int unsigned H = 1280, V = 1024, PF = 10, DW = 2, STEP = 4, BC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] x = '0, y = '0;
  logic        req = 1'b0, fs = 1'b0, auto_m = 1'b0, frz = 1'b0;
  logic [3:0]  sel = '0;
  logic [15:0] data;
  logic        valid;
  logic [3:0]  mode_cur;

  display_pattern_gen #(
    .H_DISP(H), .V_DISP(V), .PIXEL_FREQUENCY(PF), .DWELL_SEC(DW),
    .GRID_SHIFT_S(4), .GRID_SHIFT_L(6), .BAR_COUNT(BC), .SCROLL_STEP(STEP)
  ) dut (
    .clk_vga_display(clk), .rst_n_display(rst_n),
    .xpos_vga_display(x), .ypos_vga_display(y),
    .pix_req(req), .frame_start(fs), .auto_mode(auto_m), .mode_sel(sel),
    .freeze(frz), .data_vga_display(data), .data_valid(valid), .mode_cur(mode_cur)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned launch; logic [15:0] data; logic valid; } pix_t;
  typedef struct { int unsigned launch; logic [3:0] mode; } mode_ent_t;
  pix_t      pq[$];
  mode_ent_t mq[$];

  int total = 0, bad = 0;
  logic [15:0] pal [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                           16'h0000, 16'hFFE0, 16'hF81F, 16'h07FF};

  // behavioural model state
  int unsigned m_time, m_secs, m_mode, m_scroll;
  bit          m_pend;
  logic        n_frz = 1'b0, n_auto = 1'b0;
  logic [3:0]  n_sel = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] ref_pix(int unsigned md, int unsigned sc,
                                          int unsigned xi, int unsigned yi, logic ri);
    int unsigned idx, xs;
    if (!ri || xi >= H || yi >= V) return 16'h0000;
    case (md)
      0: return (((xi >> 4) ^ (yi >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
      1: return (((xi >> 6) ^ (yi >> 6)) & 1) != 0 ? 16'hFFFF : 16'h0000;
      2: begin idx = yi / (V / BC); if (idx > BC - 1) idx = BC - 1; return pal[idx[2:0]]; end
      3: begin idx = xi / (H / BC); if (idx > BC - 1) idx = BC - 1; return pal[idx[2:0]]; end
      4: return 16'hF800;
      5: return 16'h07E0;
      6: return 16'h001F;
      7: return 16'((xi * yi) % 65536);
      8: begin
           xs = (xi + sc) % 4096;
           return (((xs >> 6) ^ (yi >> 6)) & 1) != 0 ? 16'hFFFF : 16'h0000;
         end
      9: return (xi == 0 || xi == H - 1 || xi == H / 2 || yi == 0 || yi == V - 1 || yi == V / 2)
                ? 16'hFFFF : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void model_reset();
    m_time = 0; m_secs = 0; m_pend = 0; m_mode = 0; m_scroll = 0;
  endfunction

  // One clock edge of elapsed behaviour: seconds from unfrozen cycle count, frame-boundary mode changes
  function automatic void model_advance(logic fsi);
    bit tick, new_pend;
    int unsigned old;
    tick = !frz && (m_time % PF == PF - 1);
    if (!frz) m_time++;
    new_pend = 0;
    if (tick) begin
      m_secs++;
      if (m_secs == DW) begin m_secs = 0; new_pend = 1; end
    end
    if (fsi) begin
      old = m_mode;
      if (!auto_m) begin
        m_mode = sel; m_secs = 0; m_pend = 0; new_pend = 0;
      end else if (m_pend) begin
        m_mode = (m_mode == 9) ? 0 : m_mode + 1; m_pend = 0;
      end
      if (m_mode == 8 && old != 8) m_scroll = 0;
      else if (old == 8 && !frz) m_scroll = (m_scroll + STEP) % 4096;
    end
    if (new_pend) m_pend = 1;
  endfunction

  task automatic issue(input logic [11:0] xi, input logic [11:0] yi, input logic ri, input logic fsi);
    pix_t p;
    mode_ent_t me;
    x = xi; y = yi; req = ri; fs = fsi;
    frz = n_frz; auto_m = n_auto; sel = n_sel;
    p.launch = cyc; p.data = ref_pix(m_mode, m_scroll, xi, yi, ri); p.valid = ri;
    pq.push_back(p);
    model_advance(fsi);
    me.launch = cyc; me.mode = 4'(m_mode);
    mq.push_back(me);
  endtask

  task automatic step(input int unsigned xi, input int unsigned yi, input logic ri, input logic fsi);
    @(posedge clk); #1;
    issue(12'(xi), 12'(yi), ri, fsi);
  endtask

  task automatic rand_pix(input logic fsi);
    step($urandom_range(0, 1400), $urandom_range(0, 1100), $urandom_range(0, 7) != 0, fsi);
  endtask

  task automatic frame();
    rand_pix(1'b1);
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0; fs = 1'b0;
    pq.delete(); mq.delete(); model_reset();
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_mode", 32'(mode_cur), 32'h0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue('0, '0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    pix_t p;
    mode_ent_t me;
    while (pq.size() > 0 && pq[0].launch + 2 <= cyc) begin
      p = pq.pop_front();
      if (p.launch + 2 != cyc) chk("pix_latency", cyc, p.launch + 2);
      else begin
        chk("pix_data", 32'(data), 32'(p.data));
        chk("pix_valid", 32'(valid), 32'(p.valid));
      end
    end
    while (mq.size() > 0 && mq[0].launch + 1 <= cyc) begin
      me = mq.pop_front();
      if (me.launch + 1 != cyc) chk("mode_latency", cyc, me.launch + 1);
      else chk("mode_cur", 32'(mode_cur), 32'(me.mode));
    end
  end

  initial begin
    do_reset(3);

    // auto cycling, one frame per 50 cycles, then with sporadic freeze
    n_auto = 1'b1;
    for (int i = 0; i < 700; i++) rand_pix(i % 50 == 49);
    for (int i = 0; i < 300; i++) begin
      n_frz = ($urandom_range(0, 7) == 0);
      rand_pix(i % 50 == 49);
    end
    n_frz = 1'b0;

    // manual: mid-frame mode_sel change waits for frame_start
    n_auto = 1'b0;
    n_sel = 4'd3;
    for (int i = 0; i < 10; i++) rand_pix(1'b0);
    frame();
    step(159, 0, 1, 0); step(160, 0, 1, 0); step(1279, 1023, 1, 0); step(1280, 0, 1, 0);

    n_sel = 4'd0; frame();
    step(16, 0, 1, 0); step(16, 16, 1, 0); step(16, 0, 0, 0); step(5, 1024, 1, 0);
    n_sel = 4'd1; frame();
    step(64, 0, 1, 0); step(63, 0, 1, 0); step(64, 64, 1, 0);
    n_sel = 4'd2; frame();
    step(0, 127, 1, 0); step(0, 128, 1, 0); step(0, 1023, 1, 0);
    n_sel = 4'd7; frame();
    step(300, 300, 1, 0); step(4095, 4095, 1, 0);

    // scrolling checker: entry clears, two further frames add 2*STEP
    n_sel = 4'd8; frame(); frame(); frame();
    step(56, 0, 1, 0); step(55, 0, 1, 0);
    n_frz = 1'b1; frame(); step(56, 0, 1, 0);
    n_frz = 1'b0; frame(); step(52, 0, 1, 0);

    n_sel = 4'd9; frame();
    step(640, 5, 1, 0); step(1279, 500, 1, 0); step(10, 10, 1, 0);
    step(0, 0, 1, 0); step(5, 1023, 1, 0); step(5, 512, 1, 0);
    n_sel = 4'd12; frame();
    step(640, 0, 1, 0); step(16, 0, 1, 0);

    for (int m = 0; m < 16; m++) begin
      n_sel = 4'(m);
      for (int i = 0; i < 10; i++) rand_pix(1'b0);
      frame();
      for (int i = 0; i < 30; i++) rand_pix(1'b0);
    end

    // mid-frame reset while showing solid green
    n_sel = 4'd5; frame();
    for (int i = 0; i < 8; i++) step(100 + i, 200, 1, 0);
    do_reset(2);
    step(16, 0, 1, 0); step(16, 16, 1, 0);
    for (int i = 0; i < 20; i++) rand_pix(1'b0);

    repeat (4) @(negedge clk);
    chk("pix_queue_drained", pq.size(), 0);
    chk("mode_queue_drained", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_pattern_gen.md
Name: display_pattern_gen

Overview:
Parametrised, frame-synchronised VGA test-pattern generator. Successor to the fixed 8-mode generator. Sits between the VGA timing generator (which supplies xpos/ypos, active-video enable and a frame-start pulse) and the RGB565 output mux. Adds:
- manual or automatic mode selection;
- tear-free mode switching, applied only at frame boundaries;
- a scrolling checkerboard and a border/crosshair alignment pattern;
- a 2-stage pipeline with an aligned valid flag.

Parameters:
H_DISP, 1280, active pixels per line
V_DISP, 1024, active lines per frame
PIXEL_FREQUENCY, 108_000_000, pixel clocks per second (28-bit)
DWELL_SEC, 3, seconds per mode in auto mode (1..31)
GRID_SHIFT_S, 4, log2 of small checker square size
GRID_SHIFT_L, 6, log2 of large checker square size
BAR_COUNT, 8, number of colour bars (1..8)
SCROLL_STEP, 1, pixels the scrolling grid moves per frame (0..255)

Ports:
clk_vga_display  in  1  pixel clock
rst_n_display  in  1  asynchronous active-low reset
xpos_vga_display  in  12  current pixel column
ypos_vga_display  in  12  current pixel row
pix_req  in  1  active-video enable from timing generator
frame_start  in  1  one-cycle pulse, once per frame, during vertical blanking
auto_mode  in  1  1 = auto-cycle modes 0..9; 0 = use mode_sel
mode_sel  in  4  manual mode request
freeze  in  1  1 = hold dwell counter and scroll offset
data_vga_display  out  16  RGB565 pixel
data_valid  out  1  pix_req delayed to align with data_vga_display
mode_cur  out  4  mode currently displayed

Behaviour:
- Reset is asynchronous and active-low on rst_n_display; clock is clk_vga_display.
- Reset values: data_vga_display=0, data_valid=0, mode_cur=0; second counter, dwell counter, pending flag and scroll offset all 0.
- Second counter (28-bit): counts 0..PIXEL_FREQUENCY-1, wraps, and emits a one-cycle sec_tick on the wrap. Held while freeze=1.
- Dwell counter: increments on sec_tick. On reaching DWELL_SEC-1 together with a sec_tick, it clears and sets advance_pending. This gives exactly DWELL_SEC seconds, with no off-by-one.
- Mode update happens only on frame_start:
  - auto_mode=1 and advance_pending: mode_cur <= (mode_cur==9) ? 0 : mode_cur+1; advance_pending clears.
  - auto_mode=0: mode_cur <= mode_sel. Dwell counter and advance_pending clear.
  - sec_tick coincident with frame_start: the tick is counted; any resulting pending flag is used at the next frame_start.
- Modes (colour index 0..7 = RED, GREEN, BLUE, WHITE, BLACK, YELLOW, MAGENTA, CYAN):
  - 0: small checker, WHITE if x[GRID_SHIFT_S]^y[GRID_SHIFT_S], else BLACK
  - 1: large checker, same rule using GRID_SHIFT_L
  - 2: horizontal bars, index = y / (V_DISP/BAR_COUNT)
  - 3: vertical bars, index = x / (H_DISP/BAR_COUNT)
  - 4/5/6: solid RED / GREEN / BLUE
  - 7: flower, low 16 bits of the 24-bit product x*y
  - 8: scrolling checker, mode 1 rule applied to x+scroll_off (12-bit, wraps mod 4096)
  - 9: WHITE on x==0, x==H_DISP-1, y==0, y==V_DISP-1, x==H_DISP/2 or y==V_DISP/2; else BLACK
  - 10..15: BLACK
- Bar rules: bar index is clamped to BAR_COUNT-1 for pixels in the division remainder. The bar divisor is an elaboration-time constant, so no runtime divider is built.
- Scroll offset:
  - clears on the frame_start that enters mode 8;
  - otherwise adds SCROLL_STEP on each frame_start while mode_cur==8 and freeze=0.
- Pipeline, latency exactly 2 cycles from xpos/ypos/pix_req to data_vga_display/data_valid:
  - stage 1 computes all candidate patterns from registered coordinates;
  - stage 2 muxes on mode_cur as held in stage 1.
- A frame_start coinciding with a pixel: pixels already in flight keep the mode they were launched with, so there is no mid-pixel tear.
- Blanking: pix_req=0, x>=H_DISP or y>=V_DISP gives data_vga_display=BLACK two cycles later. data_valid still follows pix_req.
- Mid-frame reset: all state returns to reset values immediately; the output restarts at mode 0 on the first pixel after release.

Test Plan:
1. Sim params PIXEL_FREQUENCY=10, DWELL_SEC=2, auto_mode=1, frame_start every 50 cycles -> mode_cur steps 0→1 at the first frame_start after cycle 20, then follows 0..9 and wraps 9→0; never changes between frame_starts.
2. auto_mode=0, mode_sel=3 changed mid-frame -> mode_cur updates only at the next frame_start. With H_DISP=1280, x=159 gives 16'hF800 and x=160 gives 16'h07E0, each exactly 2 cycles after input.
3. Mode 0, (x,y)=(16,0) -> 16'hFFFF; (16,16) -> 16'h0000. Mode 7, (x,y)=(300,300) -> 16'h5F90 (90000 mod 65536). pix_req=0 -> data 0, data_valid 0.
4. Mode 8, SCROLL_STEP=4, three frame_starts after entry -> offset 8. Pixel x=56 displays as x=64 (WHITE at y=0). With freeze=1 the offset is held.
5. Mode 9 at (640,5), (1279,500), (10,10) -> FFFF, FFFF, 0000. mode_sel=12 -> all pixels 0000.
6. Assert rst_n_display low mid-frame in mode 5 -> data 0, valid 0, mode_cur 0 immediately. After release the first valid pixel follows mode 0.
